// File: rtl/frontpanel_spi_pkg.sv
// Shared types for the front panel SPI framer.
//   state_t      : framer FSM states
//   fifo_entry_t : one queued byte plus its end-of-frame marker
//   max3         : width helper for the shared timing counter
package frontpanel_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      WAIT,
      GAP,
      CS_HOLD,
      CS_IDLE
   } state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/frontpanel_byte_fifo.sv
// Synchronous byte FIFO holding {last, data} entries for the framer.
// Ports:
//   clk, rst_n       : clock, async active-low reset (empties the FIFO)
//   push_i / wdata_i : write request and entry; ignored while full
//   pop_i / rdata_o  : read request and head entry (head valid when !empty_o)
//   full_o, empty_o  : registered status flags
//   count_o          : registered occupancy
module frontpanel_byte_fifo
   import frontpanel_spi_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  fifo_entry_t       wdata_i,
   input  logic              pop_i,
   output fifo_entry_t       rdata_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fifo_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               full_q;
   logic               empty_q;
   logic               push_ok;
   logic               pop_ok;

   // A push while full is dropped even if a pop happens in the same cycle.
   assign push_ok = push_i & ~full_q;
   assign pop_ok  = pop_i & ~empty_q;
   assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/frontpanel_spi_framer.sv
// Frames firmware-queued bytes onto the front panel SPI shifter.
// Owns cs_n with setup/hold/idle spacing and hands one byte at a time to the
// shifter (shift_en / shift_done handshake). wr_commit marks the last byte of
// a frame so a whole display transaction can be queued at once.
// Build option: define FRONTPANEL_GAP_TIMEOUT_EN to force-close a frame that
// sits in GAP with an empty FIFO for GAP_TIMEOUT clocks.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   wr_en, wr_data, wr_commit     : byte push, commit marks last byte of frame
//   fifo_full, busy               : FIFO full (registered), activity status
//   overflow, gap_timeout         : sticky error flags, cleared by clear_flags
//   frame_done                    : one-cycle pulse as cs_n rises
//   shift_en, tx_data, shift_done : handshake with the SPI shifter
//   cs_n                          : front panel chip select
//
// state    | meaning
// IDLE     | cs_n high, waiting for a queued byte
// CS_SETUP | cs_n low, counting setup time before the first byte
// SHIFT    | shift_en high for one cycle, byte handed to shifter
// WAIT     | waiting for shift_done
// GAP      | mid-frame, FIFO empty, cs_n held low
// CS_HOLD  | last byte done, counting hold time before cs_n rises
// CS_IDLE  | cs_n high, enforcing minimum time between frames
module frontpanel_spi_framer
   import frontpanel_spi_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned CS_SETUP_CYCLES = 50,
   parameter int unsigned CS_HOLD_CYCLES  = 50,
   parameter int unsigned CS_IDLE_CYCLES  = 100,
   parameter int unsigned GAP_TIMEOUT     = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       wr_commit,
   output logic       fifo_full,
   output logic       busy,
   output logic       overflow,
   input  logic       clear_flags,
   output logic       gap_timeout,
   output logic       frame_done,
   output logic       shift_en,
   output logic [7:0] tx_data,
   input  logic       shift_done,
   output logic       cs_n
);

   localparam int unsigned CNT_W  = $clog2(max3(CS_SETUP_CYCLES, CS_HOLD_CYCLES, CS_IDLE_CYCLES) + 1);
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(CS_IDLE_CYCLES - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CS_SETUP_CYCLES < 1 ||
       CS_HOLD_CYCLES < 1 || CS_IDLE_CYCLES < 1 || GAP_TIMEOUT < 1) begin : g_param_check
      $error("frontpanel_spi_framer: illegal parameter value");
   end

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               cs_n_q;
   logic               shift_en_q;
   logic [7:0]         tx_data_q;
   logic               last_q;
   logic               frame_done_q;
   logic               overflow_q;

   fifo_entry_t        fifo_wdata;
   fifo_entry_t        fifo_head;
   logic               fifo_empty;
   logic               fifo_full_w;
   logic [FCNT_W-1:0]  fifo_count;
   logic               load_byte;
   logic               gap_expired;

   assign fifo_wdata.last = wr_commit;
   assign fifo_wdata.data = wr_data;

   // Every transition into SHIFT pops the head entry in the same edge.
   assign load_byte = ((state_q == CS_SETUP) && (cnt_q == '0)) ||
                      ((state_q == WAIT) && shift_done && !last_q && !fifo_empty) ||
                      ((state_q == GAP) && !fifo_empty);

   frontpanel_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (wr_en),
      .wdata_i (fifo_wdata),
      .pop_i   (load_byte),
      .rdata_o (fifo_head),
      .full_o  (fifo_full_w),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef FRONTPANEL_GAP_TIMEOUT_EN
   localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TIMEOUT - 1);

   logic [GAP_W-1:0] gap_cnt_q;
   logic             gap_timeout_q;

   assign gap_expired = (state_q == GAP) && fifo_empty && (gap_cnt_q == '0);

   // Held at the reload value outside GAP so every GAP visit starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt_q     <= GAP_LOAD;
         gap_timeout_q <= 1'b0;
      end else begin
         if (state_q != GAP || !fifo_empty) begin
            gap_cnt_q <= GAP_LOAD;
         end else if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
         end
         gap_timeout_q <= (gap_timeout_q & ~clear_flags) | gap_expired;
      end
   end

   assign gap_timeout = gap_timeout_q;
`else
   assign gap_expired = 1'b0;
   assign gap_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= (overflow_q & ~clear_flags) | (wr_en & fifo_full_w);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         cs_n_q       <= 1'b1;
         shift_en_q   <= 1'b0;
         tx_data_q    <= 8'h00;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         shift_en_q   <= 1'b0;
         frame_done_q <= 1'b0;
         if (load_byte) begin
            state_q    <= SHIFT;
            shift_en_q <= 1'b1;
            tx_data_q  <= fifo_head.data;
            last_q     <= fifo_head.last;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!fifo_empty) begin
                     state_q <= CS_SETUP;
                     cs_n_q  <= 1'b0;
                     cnt_q   <= SETUP_LOAD;
                  end
               end
               CS_SETUP: cnt_q <= cnt_q - CNT_W'(1);
               SHIFT:    state_q <= WAIT;
               WAIT: begin
                  if (shift_done) begin
                     if (last_q) begin
                        state_q <= CS_HOLD;
                        cnt_q   <= HOLD_LOAD;
                     end else begin
                        state_q <= GAP;
                     end
                  end
               end
               GAP: begin
                  if (gap_expired) begin
                     state_q <= CS_HOLD;
                     cnt_q   <= HOLD_LOAD;
                  end
               end
               CS_HOLD: begin
                  if (cnt_q == '0) begin
                     state_q      <= CS_IDLE;
                     cs_n_q       <= 1'b1;
                     frame_done_q <= 1'b1;
                     cnt_q        <= IDLE_LOAD;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               CS_IDLE: begin
                  if (cnt_q == '0) begin
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign fifo_full  = fifo_full_w;
   assign busy       = (state_q != IDLE) || (fifo_count != '0);
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;
   assign shift_en   = shift_en_q;
   assign tx_data    = tx_data_q;
   assign cs_n       = cs_n_q;

endmodule

// File: tb/tb_frontpanel_spi_framer.sv
// Self-checking bench for frontpanel_spi_framer with short timing parameters.
module tb_frontpanel_spi_framer;

   localparam int SETUP  = 4;
   localparam int HOLD   = 3;
   localparam int IDLE_C = 5;
   localparam int DEPTH  = 16;
   localparam int GAP_TO = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_commit;
   logic       fifo_full;
   logic       busy;
   logic       overflow;
   logic       clear_flags;
   logic       gap_timeout;
   logic       frame_done;
   logic       shift_en;
   logic [7:0] tx_data;
   logic       shift_done;
   logic       cs_n;

   int total = 0;
   int bad   = 0;
   int se_cnt = 0;
   int fd_cnt = 0;
   int tx40_cnt = 0;

   frontpanel_spi_framer #(
      .FIFO_DEPTH      (DEPTH),
      .CS_SETUP_CYCLES (SETUP),
      .CS_HOLD_CYCLES  (HOLD),
      .CS_IDLE_CYCLES  (IDLE_C),
      .GAP_TIMEOUT     (GAP_TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .wr_commit   (wr_commit),
      .fifo_full   (fifo_full),
      .busy        (busy),
      .overflow    (overflow),
      .clear_flags (clear_flags),
      .gap_timeout (gap_timeout),
      .frame_done  (frame_done),
      .shift_en    (shift_en),
      .tx_data     (tx_data),
      .shift_done  (shift_done),
      .cs_n        (cs_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (shift_en === 1'b1) se_cnt <= se_cnt + 1;
      if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
      if (shift_en === 1'b1 && tx_data === 8'h40) tx40_cnt <= tx40_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [7:0] data;
      int         done_dly;
      int         exp_en_edge;
      logic [7:0] exp_tx;
      int         exp_hold;
      int         exp_idle;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic last);
      wr_en = 1'b1;
      wr_data = d;
      wr_commit = last;
      tick();
      wr_en = 1'b0;
      wr_commit = 1'b0;
   endtask

   task automatic wait_shift_en(output int n);
      n = 0;
      while (shift_en !== 1'b1 && n < 500) begin tick(); n++; end
   endtask

   task automatic wait_cs_high(output int n);
      n = 0;
      while (cs_n !== 1'b1 && n < 500) begin tick(); n++; end
   endtask

   task automatic wait_not_busy(output int n);
      n = 0;
      while (busy !== 1'b0 && n < 500) begin tick(); n++; end
   endtask

   // Called in or after the shift_en cycle: answer with shift_done, expect next byte.
   task automatic serve(input logic [7:0] exp, input int dly, input string name);
      repeat (dly) tick();
      shift_done = 1'b1;
      tick();
      shift_done = 1'b0;
      check({name, "_shift_en"}, shift_en, 1'b1);
      check({name, "_tx"}, tx_data, exp);
      check({name, "_cs_low"}, cs_n, 1'b0);
   endtask

   task automatic close_frame(input int dly, input string name);
      int n;
      repeat (dly) tick();
      shift_done = 1'b1;
      tick();
      shift_done = 1'b0;
      wait_cs_high(n);
      check({name, "_hold"}, n, HOLD);
      check({name, "_frame_done"}, frame_done, 1'b1);
      wait_not_busy(n);
      check({name, "_idle"}, n, IDLE_C);
   endtask

   initial begin
      int n, fd0, se0, hi;

      vecs[0] = '{data: 8'hA5, done_dly: 20, exp_en_edge: 5, exp_tx: 8'hA5, exp_hold: 3, exp_idle: 5};
      vecs[1] = '{data: 8'h3C, done_dly: 1,  exp_en_edge: 5, exp_tx: 8'h3C, exp_hold: 3, exp_idle: 5};
      vecs[2] = '{data: 8'h00, done_dly: 7,  exp_en_edge: 5, exp_tx: 8'h00, exp_hold: 3, exp_idle: 5};
      vecs[3] = '{data: 8'hFF, done_dly: 3,  exp_en_edge: 5, exp_tx: 8'hFF, exp_hold: 3, exp_idle: 5};

      rst_n = 1'b0;
      wr_en = 1'b0;
      wr_data = 8'h00;
      wr_commit = 1'b0;
      clear_flags = 1'b0;
      shift_done = 1'b0;
      repeat (3) tick();
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_shift_en", shift_en, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_gap_timeout", gap_timeout, 1'b0);
      check("rst_fifo_full", fifo_full, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", busy, 1'b0);

      // Single-byte frames from the vector table.
      for (int i = 0; i < 4; i++) begin
         fd0 = fd_cnt;
         se0 = se_cnt;
         wr_en = 1'b1;
         wr_data = vecs[i].data;
         wr_commit = 1'b1;
         tick();
         wr_en = 1'b0;
         wr_commit = 1'b0;
         check($sformatf("v%0d_cs_edge0", i), cs_n, 1'b1);
         tick();
         check($sformatf("v%0d_cs_edge1", i), cs_n, 1'b0);
         wait_shift_en(n);
         check($sformatf("v%0d_en_edge", i), n + 1, vecs[i].exp_en_edge);
         check($sformatf("v%0d_tx", i), tx_data, vecs[i].exp_tx);
         repeat (vecs[i].done_dly) tick();
         check($sformatf("v%0d_en_one_cycle", i), shift_en, 1'b0);
         shift_done = 1'b1;
         tick();
         shift_done = 1'b0;
         wait_cs_high(n);
         check($sformatf("v%0d_hold", i), n, vecs[i].exp_hold);
         check($sformatf("v%0d_frame_done", i), frame_done, 1'b1);
         wait_not_busy(n);
         check($sformatf("v%0d_idle", i), n, vecs[i].exp_idle);
         check($sformatf("v%0d_fd_pulses", i), fd_cnt - fd0, 1);
         check($sformatf("v%0d_en_pulses", i), se_cnt - se0, 1);
      end

      // Three-byte frame, all queued up front.
      fd0 = fd_cnt;
      se0 = se_cnt;
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      push(8'h03, 1'b1);
      check("f3_cs_low", cs_n, 1'b0);
      wait_shift_en(n);
      check("f3_en_edge", n, 3);
      check("f3_tx0", tx_data, 8'h01);
      serve(8'h02, 2, "f3_b1");
      serve(8'h03, 5, "f3_b2");
      close_frame(1, "f3_close");
      check("f3_en_pulses", se_cnt - se0, 3);
      check("f3_fd_pulses", fd_cnt - fd0, 1);

`ifdef FRONTPANEL_GAP_TIMEOUT_EN
      // Lone byte without commit: frame is force-closed after GAP_TIMEOUT.
      fd0 = fd_cnt;
      push(8'h77, 1'b0);
      wait_shift_en(n);
      check("gto_tx", tx_data, 8'h77);
      tick();
      shift_done = 1'b1;
      tick();
      shift_done = 1'b0;
      n = 0;
      while (gap_timeout !== 1'b1 && n < 500) begin tick(); n++; end
      check("gto_expiry", n, GAP_TO);
      check("gto_cs_still_low", cs_n, 1'b0);
      wait_cs_high(n);
      check("gto_hold", n, HOLD);
      check("gto_frame_done", frame_done, 1'b1);
      wait_not_busy(n);
      check("gto_idle", n, IDLE_C);
      check("gto_fd_pulses", fd_cnt - fd0, 1);
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("gto_cleared", gap_timeout, 1'b0);
`else
      // Mid-frame gap: cs_n stays low until the next byte arrives.
      push(8'h10, 1'b0);
      wait_shift_en(n);
      check("gap_tx0", tx_data, 8'h10);
      tick();
      shift_done = 1'b1;
      tick();
      shift_done = 1'b0;
      hi = 0;
      repeat (200) begin
         tick();
         if (cs_n !== 1'b0) hi++;
      end
      check("gap_cs_high_cycles", hi, 0);
      check("gap_busy", busy, 1'b1);
      push(8'h11, 1'b1);
      check("gap_no_early_en", shift_en, 1'b0);
      tick();
      check("gap_en_after_push", shift_en, 1'b1);
      check("gap_tx1", tx_data, 8'h11);
      close_frame(2, "gap_close");
      check("gap_timeout_tied", gap_timeout, 1'b0);
`endif

      // Overflow: fill the FIFO while the shifter stalls on the first byte.
      push(8'h20, 1'b0);
      wait_shift_en(n);
      check("ovf_tx0", tx_data, 8'h20);
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1;
         wr_data = 8'h30 + 8'(i);
         wr_commit = (i == DEPTH - 1);
         tick();
      end
      wr_en = 1'b0;
      wr_commit = 1'b0;
      check("ovf_full", fifo_full, 1'b1);
      check("ovf_not_yet", overflow, 1'b0);
      // 17th write with a pop and clear_flags in the same cycle.
      wr_en = 1'b1;
      wr_data = 8'h40;
      wr_commit = 1'b1;
      shift_done = 1'b1;
      clear_flags = 1'b1;
      tick();
      wr_en = 1'b0;
      wr_commit = 1'b0;
      shift_done = 1'b0;
      clear_flags = 1'b0;
      check("ovf_set_wins", overflow, 1'b1);
      check("ovf_pop_en", shift_en, 1'b1);
      check("ovf_pop_tx", tx_data, 8'h30);
      check("ovf_full_after_pop", fifo_full, 1'b0);
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("ovf_cleared", overflow, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         serve(8'h30 + 8'(i), 1, $sformatf("ovf_b%0d", i));
      end
      close_frame(1, "ovf_close");
      check("ovf_dropped_never_sent", tx40_cnt, 0);

      // Reset while waiting for shift_done.
      push(8'h55, 1'b1);
      wait_shift_en(n);
      tick();
      check("mrst_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mrst_cs_async", cs_n, 1'b1);
      check("mrst_busy", busy, 1'b0);
      check("mrst_shift_en", shift_en, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      se0 = se_cnt;
      tick();
      shift_done = 1'b1;
      tick();
      shift_done = 1'b0;
      repeat (20) tick();
      check("mrst_no_shift_en", se_cnt - se0, 0);
      check("mrst_cs_high", cs_n, 1'b1);
      check("mrst_idle", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
